// File: rtl/mod_exp_pkg.sv
// Shared constants, product opcodes and FSM state encoding for the
// modular-exponentiation controller.
package mod_exp_pkg;

   localparam int unsigned BIT_LEN_DEF = 256;
   localparam int unsigned ABITS_DEF   = 8;
   localparam int unsigned DBITS_DEF   = 256;
   localparam int unsigned EXP_LEN_W   = 10;
   localparam int unsigned OP_W        = 2;
   localparam int unsigned CYC_W       = 32;

   typedef enum logic [OP_W-1:0] {
      OPXX = 2'd0,
      OPXM = 2'd1,
      OPX1 = 2'd2
   } op_e;

   typedef enum logic [4:0] {
      IDLE      = 5'd0,
      LD_X_LO   = 5'd1,
      LD_X_HI   = 5'd2,
      LD_B_LO   = 5'd3,
      LD_B_HI   = 5'd4,
      SQR       = 5'd5,
      SQR_WAIT  = 5'd6,
      SQR_WB_LO = 5'd7,
      SQR_WB_HI = 5'd8,
      MUL       = 5'd9,
      MUL_WAIT  = 5'd10,
      MUL_WB_LO = 5'd11,
      MUL_WB_HI = 5'd12,
      NEXT      = 5'd13,
      CONV      = 5'd14,
      CONV_WAIT = 5'd15,
      DONE      = 5'd16
   } state_e;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Montgomery-product handshake plus BRAM write port 2, shared between the
// exponentiation controller (master) and the datapath side (slave).
interface mod_exp_ctrl_if #(
   parameter int unsigned bitLen = mod_exp_pkg::BIT_LEN_DEF,
   parameter int unsigned ABITS  = mod_exp_pkg::ABITS_DEF,
   parameter int unsigned DBITS  = mod_exp_pkg::DBITS_DEF
);

   logic                         mp_start;
   logic [mod_exp_pkg::OP_W-1:0] mp_op_code;
   logic                         mp_stop;
   logic [bitLen:0]              mp_P;
   logic [ABITS-1:0]             wr_addr2;
   logic [DBITS-1:0]             wr_data2;
   logic                         wr_en2;

   modport master (
      output mp_start, mp_op_code, wr_addr2, wr_data2, wr_en2,
      input  mp_stop, mp_P
   );

   modport slave (
      input  mp_start, mp_op_code, wr_addr2, wr_data2, wr_en2,
      output mp_stop, mp_P
   );

endinterface

// File: rtl/exp_bit_iter.sv
// Exponent bit walker: holds the captured exponent MSB-aligned on the top
// significant bit and counts the bits still to be processed.
module exp_bit_iter
   import mod_exp_pkg::*;
#(
   parameter int unsigned bitLen = BIT_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 advance,
   input  logic [bitLen-1:0]    exponent,
   input  logic [EXP_LEN_W-1:0] exp_len,
   output logic                 cur_bit_c,
   output logic                 last_c,
   output logic                 empty_c
);

   logic [bitLen-1:0]    sh;
   logic [EXP_LEN_W-1:0] remain;
   logic [EXP_LEN_W-1:0] len_clamped_c;

   // An exp_len wider than the operand cannot select more bits than exist.
   always_comb begin
      len_clamped_c = exp_len;
      if (32'(exp_len) > bitLen) len_clamped_c = EXP_LEN_W'(bitLen);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh     <= '0;
         remain <= '0;
      end else if (load) begin
         sh     <= exponent << (bitLen - 32'(len_clamped_c));
         remain <= len_clamped_c;
      end else if (advance) begin
         sh     <= sh << 1;
         remain <= remain - EXP_LEN_W'(1);
      end
   end

   assign cur_bit_c = sh[bitLen-1];
   assign last_c    = (remain == EXP_LEN_W'(1));
   assign empty_c   = (remain == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier
// and its operand BRAM. Optional cycle counter enabled by MOD_EXP_PERF_EN.
module mod_exp_ctrl
   import mod_exp_pkg::*;
#(
   parameter int unsigned bitLen = BIT_LEN_DEF,
   parameter int unsigned ABITS  = ABITS_DEF,
   parameter int unsigned DBITS  = DBITS_DEF,
   parameter int unsigned X_ADDR = 0,
   parameter int unsigned B_ADDR = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [bitLen-1:0]    base_mont,
   input  logic [bitLen-1:0]    one_mont,
   input  logic [bitLen-1:0]    exponent,
   input  logic [EXP_LEN_W-1:0] exp_len,
   mod_exp_ctrl_if.master       mp,
   output logic                 busy,
   output logic                 done,
   output logic [bitLen-1:0]    result
`ifdef MOD_EXP_PERF_EN
   ,
   output logic [CYC_W-1:0]     cycles
`endif
);

   localparam logic [ABITS-1:0] X_LO = ABITS'(X_ADDR);
   localparam logic [ABITS-1:0] X_HI = ABITS'(X_ADDR + 1);
   localparam logic [ABITS-1:0] B_LO = ABITS'(B_ADDR);
   localparam logic [ABITS-1:0] B_HI = ABITS'(B_ADDR + 1);

   state_e            state;
   logic [bitLen-1:0] base_q;
   logic              p_hi;
   logic              load_c, advance_c, cur_bit_c, last_c, empty_c;

   assign load_c    = (state == IDLE) && start;
   assign advance_c = (state == NEXT) && !last_c;

   exp_bit_iter #(.bitLen(bitLen)) u_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c),
      .advance   (advance_c),
      .exponent  (exponent),
      .exp_len   (exp_len),
      .cur_bit_c (cur_bit_c),
      .last_c    (last_c),
      .empty_c   (empty_c)
   );

   // Outputs are registered for the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         result        <= '0;
         base_q        <= '0;
         p_hi          <= 1'b0;
         mp.mp_start   <= 1'b0;
         mp.mp_op_code <= OPXX;
         mp.wr_en2     <= 1'b0;
         mp.wr_addr2   <= '0;
         mp.wr_data2   <= '0;
      end else begin
         done      <= 1'b0;
         mp.wr_en2 <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state       <= LD_X_LO;
               busy        <= 1'b1;
               base_q      <= base_mont;
               mp.wr_en2   <= 1'b1;
               mp.wr_addr2 <= X_LO;
               mp.wr_data2 <= DBITS'(one_mont);
            end
            LD_X_LO: begin
               state       <= LD_X_HI;
               mp.wr_en2   <= 1'b1;
               mp.wr_addr2 <= X_HI;
               mp.wr_data2 <= '0;
            end
            LD_X_HI: begin
               state       <= LD_B_LO;
               mp.wr_en2   <= 1'b1;
               mp.wr_addr2 <= B_LO;
               mp.wr_data2 <= DBITS'(base_q);
            end
            LD_B_LO: begin
               state       <= LD_B_HI;
               mp.wr_en2   <= 1'b1;
               mp.wr_addr2 <= B_HI;
               mp.wr_data2 <= '0;
            end
            LD_B_HI: begin
               mp.mp_start   <= 1'b1;
               state         <= empty_c ? CONV : SQR;
               mp.mp_op_code <= empty_c ? OPX1 : OPXX;
            end
            SQR:  state <= SQR_WAIT;
            MUL:  state <= MUL_WAIT;
            CONV: state <= CONV_WAIT;
            SQR_WAIT, MUL_WAIT: if (mp.mp_stop) begin
               state       <= (state == SQR_WAIT) ? SQR_WB_LO : MUL_WB_LO;
               mp.mp_start <= 1'b0;
               p_hi        <= mp.mp_P[bitLen];
               mp.wr_en2   <= 1'b1;
               mp.wr_addr2 <= X_LO;
               mp.wr_data2 <= DBITS'(mp.mp_P[bitLen-1:0]);
            end
            SQR_WB_LO, MUL_WB_LO: begin
               state       <= (state == SQR_WB_LO) ? SQR_WB_HI : MUL_WB_HI;
               mp.wr_en2   <= 1'b1;
               mp.wr_addr2 <= X_HI;
               mp.wr_data2 <= DBITS'(p_hi);
            end
            SQR_WB_HI: begin
               if (cur_bit_c) begin
                  state         <= MUL;
                  mp.mp_start   <= 1'b1;
                  mp.mp_op_code <= OPXM;
               end else begin
                  state <= NEXT;
               end
            end
            MUL_WB_HI: state <= NEXT;
            NEXT: begin
               mp.mp_start   <= 1'b1;
               state         <= last_c ? CONV : SQR;
               mp.mp_op_code <= last_c ? OPX1 : OPXX;
            end
            CONV_WAIT: if (mp.mp_stop) begin
               state       <= DONE;
               mp.mp_start <= 1'b0;
               result      <= mp.mp_P[bitLen-1:0];
               done        <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MOD_EXP_PERF_EN
   // Counts busy cycles up to DONE, then holds; saturates rather than wraps.
   always_ff @(posedge clk) begin
      if (rst)                                           cycles <= '0;
      else if (load_c)                                   cycles <= '0;
      else if (busy && state != DONE && cycles != '1)    cycles <= cycles + CYC_W'(1);
   end
`endif

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier and BRAM, plain
// modular-power reference, per-cycle protocol checks and directed literals.
module tb_mod_exp_ctrl;
   import mod_exp_pkg::*;

   localparam int unsigned BL = 10;
   localparam int unsigned AB = 4;
   localparam int unsigned DB = 16;
   localparam longint      M  = 589;
   localparam longint      RM = 435;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [BL-1:0] base_mont, one_mont, exponent, result;
   logic [9:0]    exp_len;
   logic          busy, done;
`ifdef MOD_EXP_PERF_EN
   logic [31:0]   cycles;
`endif

   mod_exp_ctrl_if #(.bitLen(BL), .ABITS(AB), .DBITS(DB)) bus ();

   mod_exp_ctrl #(.bitLen(BL), .ABITS(AB), .DBITS(DB), .X_ADDR(0), .B_ADDR(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_mont (base_mont),
      .one_mont  (one_mont),
      .exponent  (exponent),
      .exp_len   (exp_len),
      .mp        (bus),
      .busy      (busy),
      .done      (done),
      .result    (result)
`ifdef MOD_EXP_PERF_EN
      ,
      .cycles    (cycles)
`endif
   );

   always #5 clk = ~clk;

   int     errors = 0, checks = 0;
   logic [15:0] mem [16];
   int     mp_st = 0, mp_lat = 0;
   logic [1:0] op_q = 2'd0;
   longint mp_res = 0;
   int     op_log[$], exp_ops[$];
   longint exp_result = 0, result_hold = 0;
   bit     exp_busy = 1'b0, got_done = 1'b0;
   int     done_cnt = 0, busy_cnt = 0, bad = 0;

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic longint modpow(input longint b, input longint e);
      longint r = 1;
      for (longint i = 0; i < e; i++) r = (r * b) % M;
      return r;
   endfunction

   // Montgomery product a*b*R^-1 (R = 2^10), result congruent mod M; OPX1 fully reduced.
   function automatic longint prod(input logic [1:0] op);
      longint x, y, t;
      x = longint'(mem[1][0]) * 1024 + longint'(mem[0][9:0]);
      case (op)
         2'd0:    y = x;
         2'd1:    y = longint'(mem[3][0]) * 1024 + longint'(mem[2][9:0]);
         default: y = 1;
      endcase
      t = x * y;
      for (int i = 0; i < 10; i++) begin
         if (t % 2 == 1) t = t + M;
         t = t / 2;
      end
      t = t % M;
      if (op != 2'd2 && $urandom_range(0, 1) == 1) t = t + M;
      return t;
   endfunction

   function automatic int count_op(input int k);
      int n = 0;
      foreach (op_log[i]) if (op_log[i] == k) n++;
      return n;
   endfunction

   initial for (int i = 0; i < 16; i++) mem[i] = '0;

   always @(posedge clk) if (bus.wr_en2) mem[bus.wr_addr2] <= bus.wr_data2;

   // Multiplier model: random latency, stray stop pulses while no product is requested.
   always @(posedge clk) begin
      if (rst) begin
         mp_st       <= 0;
         bus.mp_stop <= 1'b0;
         bus.mp_P    <= '0;
      end else begin
         case (mp_st)
            0: begin
               bus.mp_stop <= 1'b0;
               if (bus.mp_start) begin
                  op_q   <= bus.mp_op_code;
                  op_log.push_back(int'(bus.mp_op_code));
                  mp_res <= prod(bus.mp_op_code);
                  mp_lat <= $urandom_range(0, 3);
                  mp_st  <= 1;
               end else if ($urandom_range(0, 7) == 0) begin
                  bus.mp_stop <= 1'b1;
                  bus.mp_P    <= 11'($urandom);
               end
            end
            1: if (mp_lat == 0) begin
               bus.mp_stop <= 1'b1;
               bus.mp_P    <= 11'(mp_res);
               mp_st       <= 2;
            end else begin
               mp_lat <= mp_lat - 1;
            end
            2: begin
               bus.mp_stop <= 1'b0;
               mp_st       <= 3;
            end
            default: mp_st <= 0;
         endcase
      end
   end

   // Expected busy/result-hold tracking from the start/done contract.
   always @(posedge clk) begin
      if (rst) begin
         exp_busy    <= 1'b0;
         result_hold <= 0;
      end else if (start && !exp_busy) begin
         exp_busy <= 1'b1;
      end else if (done) begin
         exp_busy    <= 1'b0;
         result_hold <= exp_result;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", busy, exp_busy);
         if (mp_st == 1 || mp_st == 2) begin
            chk("mp_start_hold", bus.mp_start, 1);
            chk("op_stable", bus.mp_op_code, op_q);
         end
         if (mp_st == 3) chk("mp_start_gap", bus.mp_start, 0);
         if (bus.mp_start) chk("no_write_in_product", bus.wr_en2, 0);
         if (!exp_busy) begin
            chk("idle_mp_start", bus.mp_start, 0);
            chk("idle_wr_en", bus.wr_en2, 0);
            chk("idle_done", done, 0);
            chk("result_hold", result, result_hold);
         end
         if (done) begin
            done_cnt++;
            got_done = 1'b1;
            chk("result", result, exp_result);
            chk("op_count", op_log.size(), exp_ops.size());
            bad = 0;
            if (op_log.size() == exp_ops.size())
               foreach (exp_ops[i]) if (op_log[i] != exp_ops[i]) bad++;
            chk("op_seq_bad", bad, 0);
`ifdef MOD_EXP_PERF_EN
            chk("cycles", cycles, busy_cnt);
`endif
         end
         if (busy && !done) busy_cnt++;
      end
   end

   task automatic wait_idle();
      int bnd = 0;
      while (busy && bnd < 500) begin
         @(posedge clk); #1;
         bnd++;
      end
      if (busy) chk("idle_timeout", 0, 1);
   endtask

   task automatic run(input int b, input int e, input int len, input bit restart);
      longint emask;
      wait_idle();
      emask      = longint'(e) & ((longint'(1) << len) - 1);
      exp_result = modpow(b, emask);
      exp_ops.delete();
      for (int i = len - 1; i >= 0; i--) begin
         exp_ops.push_back(int'(OPXX));
         if (((e >> i) & 1) == 1) exp_ops.push_back(int'(OPXM));
      end
      exp_ops.push_back(int'(OPX1));
      op_log.delete();
      got_done  = 1'b0;
      done_cnt  = 0;
      busy_cnt  = 0;
      base_mont = BL'((b * 1024) % 589);
      one_mont  = BL'(RM);
      exponent  = BL'(e);
      exp_len   = 10'(len);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      base_mont = BL'($urandom);
      one_mont  = BL'($urandom);
      exponent  = BL'($urandom);
      exp_len   = 10'($urandom_range(0, 10));
      for (int c = 0; c < 4000 && !got_done; c++) begin
         @(posedge clk); #1;
         if (restart && c == 3) begin
            start     = 1'b1;
            base_mont = BL'($urandom);
            exponent  = BL'($urandom);
            exp_len   = 10'($urandom_range(1, 10));
         end
         if (restart && c == 4) start = 1'b0;
      end
      if (!got_done) chk("done_timeout", 0, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_mp_start", bus.mp_start, 0);
      chk("rst_op_code", bus.mp_op_code, 0);
      chk("rst_wr_en2", bus.wr_en2, 0);
      chk("rst_wr_addr2", bus.wr_addr2, 0);
      chk("rst_wr_data2", bus.wr_data2, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
   endtask

   task automatic run_reset_in_wait();
      int bnd = 0;
      wait_idle();
      op_log.delete();
      busy_cnt  = 0;
      base_mont = BL'((11 * 1024) % 589);
      one_mont  = BL'(RM);
      exponent  = BL'(10'h3FF);
      exp_len   = 10'd10;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!(mp_st == 1 && op_q == 2'd0) && bnd < 200) begin
         @(posedge clk); #1;
         bnd++;
      end
      chk("reach_sqr_wait", (mp_st == 1 && op_q == 2'd0) ? 1 : 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      base_mont = '0; one_mont = '0; exponent = '0; exp_len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;

      // 2^5 mod 589 with a 3-bit exponent: base_mont = 281.
      run(2, 5, 3, 1'b0);
      chk("lit_2pow5", result, 32);
      chk("lit_2pow5_done", done_cnt, 1);

      // 3^4: bits 100 -> three squares, one multiply, one conversion.
      run(3, 4, 3, 1'b0);
      chk("lit_3pow4", result, 81);
      chk("lit_n_opxx", count_op(0), 3);
      chk("lit_n_opxm", count_op(1), 1);
      chk("lit_n_opx1", count_op(2), 1);

      // Empty exponent goes straight to conversion.
      run(5, 10'h3FF, 0, 1'b0);
      chk("lit_len0_result", result, 1);
      chk("lit_len0_nops", op_log.size(), 1);
      if (op_log.size() > 0) chk("lit_len0_op", op_log[0], 2);

      // Second start mid-run must be ignored.
      run(7, 10'h2D5, 10, 1'b1);
      chk("lit_restart_7pow725", result, modpow(7, 725));

      run_reset_in_wait();
      run(2, 5, 3, 1'b0);
      chk("lit_after_reset", result, 32);

      for (int k = 0; k < 12; k++)
         run(int'($urandom_range(0, 588)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 10)), k[1:0] == 2'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
